// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: opcodes, FSM states
// and the fixed result returned for a divide-by-zero request.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [15:0] ERR_DIVZERO_RESULT = 16'hFFFF;
  localparam logic [15:0] ERR_TIMEOUT_RESULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } seq_state_t;

  // Divider results are returned as {remainder, quotient}.
  function automatic logic [15:0] pack_div(input logic [7:0] quot, input logic [7:0] rem);
    return {rem, quot};
  endfunction

endpackage

// File: rtl/alu_sequencer_timeout.sv
// Wait-cycle counter for the sequencer. Cleared while the start pulse is
// out, counts each WAIT cycle without a done, and flags the last allowed
// cycle so the FSM can abort a unit that never answers.
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LAST_COUNT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the 8-bit ALU. Accepts one operation through a
// valid/ready handshake, pulses the start line of the selected unit, waits
// for its done (or a timeout) and presents a packed result with an error
// flag until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  s,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [7:0]  opa,
  output logic [7:0]  opb,
  output logic        startadd,
  output logic        startsub,
  output logic        startmultiplier,
  output logic        startdiv,
  input  logic        add_done,
  input  logic [8:0]  add_res,
  input  logic        mul_done,
  input  logic [15:0] mul_res,
  input  logic        div_done,
  input  logic [7:0]  div_quot,
  input  logic [7:0]  div_rem,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result,
  output logic        err,
  output logic        busy
);

  seq_state_t  state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic [7:0]  opa_reg, opa_next;
  logic [7:0]  opb_reg, opb_next;
  logic [15:0] result_reg, result_next;
  logic        err_reg, err_next;
  logic        res_valid_reg, res_valid_next;
  logic        startadd_reg, startadd_next;
  logic        startsub_reg, startsub_next;
  logic        startmul_reg, startmul_next;
  logic        startdiv_reg, startdiv_next;

  logic        unit_done;
  logic [15:0] unit_result;
  logic        cnt_clr;
  logic        cnt_en;
  logic        expired;

  // Select the done and result of the unit the latched opcode targets;
  // done lines of other units are ignored.
  always_comb begin
    unit_done   = 1'b0;
    unit_result = 16'h0000;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        unit_done   = add_done;
        unit_result = {7'b0, add_res};
      end
      OP_MUL: begin
        unit_done   = mul_done;
        unit_result = mul_res;
      end
      default: begin
        unit_done   = div_done;
        unit_result = pack_div(div_quot, div_rem);
      end
    endcase
  end

  // Counter is cleared during ISSUE and runs only while waiting without done.
  assign cnt_clr = (state_reg == ST_ISSUE);
  assign cnt_en  = (state_reg == ST_WAIT) && !unit_done;

  seq_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Next-state and next-output logic; start pulses are computed on the
  // accept edge so the registered lines are high only during ISSUE.
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    opa_next       = opa_reg;
    opb_next       = opb_reg;
    result_next    = result_reg;
    err_next       = err_reg;
    res_valid_next = res_valid_reg;
    startadd_next  = 1'b0;
    startsub_next  = 1'b0;
    startmul_next  = 1'b0;
    startdiv_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (op_valid) begin
          op_next  = s;
          opa_next = a;
          opb_next = b;
          if ((s == OP_DIV) && (b == 8'h00)) begin
            // Divide-by-zero is answered directly without starting the divider.
            result_next    = ERR_DIVZERO_RESULT;
            err_next       = 1'b1;
            res_valid_next = 1'b1;
            state_next     = ST_HOLD;
          end else begin
            startadd_next = (s == OP_ADD) || (s == OP_SUB);
            startsub_next = (s == OP_SUB);
            startmul_next = (s == OP_MUL);
            startdiv_next = (s == OP_DIV);
            state_next    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A done in the final allowed cycle takes precedence over the timeout.
        if (unit_done) begin
          result_next    = unit_result;
          err_next       = 1'b0;
          res_valid_next = 1'b1;
          state_next     = ST_HOLD;
        end else if (expired) begin
          result_next    = ERR_TIMEOUT_RESULT;
          err_next       = 1'b1;
          res_valid_next = 1'b1;
          state_next     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      opa_reg       <= 8'h00;
      opb_reg       <= 8'h00;
      result_reg    <= 16'h0000;
      err_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      startadd_reg  <= 1'b0;
      startsub_reg  <= 1'b0;
      startmul_reg  <= 1'b0;
      startdiv_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      opa_reg       <= opa_next;
      opb_reg       <= opb_next;
      result_reg    <= result_next;
      err_reg       <= err_next;
      res_valid_reg <= res_valid_next;
      startadd_reg  <= startadd_next;
      startsub_reg  <= startsub_next;
      startmul_reg  <= startmul_next;
      startdiv_reg  <= startdiv_next;
    end
  end

  assign op_ready        = (state_reg == ST_IDLE);
  assign busy            = (state_reg != ST_IDLE);
  assign opa             = opa_reg;
  assign opb             = opb_reg;
  assign result          = result_reg;
  assign err             = err_reg;
  assign res_valid       = res_valid_reg;
  assign startadd        = startadd_reg;
  assign startsub        = startsub_reg;
  assign startmultiplier = startmul_reg;
  assign startdiv        = startdiv_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays the role of the units,
// driving done/result lines by hand, and checks against hand-computed values.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  s;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        startadd;
  logic        startsub;
  logic        startmultiplier;
  logic        startdiv;
  logic        add_done;
  logic [8:0]  add_res;
  logic        mul_done;
  logic [15:0] mul_res;
  logic        div_done;
  logic [7:0]  div_quot;
  logic [7:0]  div_rem;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .TIMEOUT_CYCLES (64),
    .CNT_W          (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .s               (s),
    .a               (a),
    .b               (b),
    .opa             (opa),
    .opb             (opb),
    .startadd        (startadd),
    .startsub        (startsub),
    .startmultiplier (startmultiplier),
    .startdiv        (startdiv),
    .add_done        (add_done),
    .add_res         (add_res),
    .mul_done        (mul_done),
    .mul_res         (mul_res),
    .div_done        (div_done),
    .div_quot        (div_quot),
    .div_rem         (div_rem),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .result          (result),
    .err             (err),
    .busy            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb);
    op_valid = 1'b1;
    s        = op;
    a        = va;
    b        = vb;
  endtask

  // Start lines packed as {add, sub, mul, div} for compact checks.
  function automatic logic [15:0] starts();
    return {12'h000, startadd, startsub, startmultiplier, startdiv};
  endfunction

  initial begin
    bit early;
    rst = 1'b1; op_valid = 1'b0; s = 2'b00; a = 8'h00; b = 8'h00;
    add_done = 1'b0; add_res = 9'h000; mul_done = 1'b0; mul_res = 16'h0000;
    div_done = 1'b0; div_quot = 8'h00; div_rem = 8'h00; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_op_ready", 16'(op_ready), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_result", result, 16'h0000);
    check("rst_err", 16'(err), 16'h0);
    check("rst_starts", starts(), 16'h0);
    $display("reset: op_ready=%b busy=%b res_valid=%b", op_ready, busy, res_valid);

    // Add C8 + 64, done two cycles after the start pulse
    drive_op(2'b00, 8'hC8, 8'h64);
    tick();
    op_valid = 1'b0; a = 8'h11; b = 8'h22;
    check("add_issue_starts", starts(), 16'b1000);
    check("add_opa", 16'(opa), 16'h00C8);
    check("add_opb", 16'(opb), 16'h0064);
    check("add_issue_op_ready", 16'(op_ready), 16'h0);
    check("add_issue_busy", 16'(busy), 16'h1);
    tick();
    check("add_wait_starts", starts(), 16'h0);
    tick();
    check("add_wait_res_valid", 16'(res_valid), 16'h0);
    add_done = 1'b1; add_res = 9'h12C;
    tick();
    add_done = 1'b0;
    check("add_res_valid", 16'(res_valid), 16'h1);
    check("add_result", result, 16'h012C);
    check("add_err", 16'(err), 16'h0);
    tick(); tick();
    check("add_hold_res_valid", 16'(res_valid), 16'h1);
    check("add_hold_result", result, 16'h012C);
    check("add_hold_starts", starts(), 16'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("add_release_res_valid", 16'(res_valid), 16'h0);
    check("add_release_op_ready", 16'(op_ready), 16'h1);
    $display("add: result=%h err=%b", result, err);

    // Sub 05 - 07, done in the first WAIT cycle
    drive_op(2'b01, 8'h05, 8'h07);
    tick();
    op_valid = 1'b0;
    check("sub_issue_starts", starts(), 16'b1100);
    tick();
    check("sub_wait_starts", starts(), 16'h0);
    add_done = 1'b1; add_res = 9'h1FE;
    tick();
    add_done = 1'b0;
    check("sub_res_valid", 16'(res_valid), 16'h1);
    check("sub_result", result, 16'h01FE);
    check("sub_err", 16'(err), 16'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("sub: result=%h err=%b", result, err);

    // Divide by zero: result one cycle after accept, no divider start
    drive_op(2'b11, 8'h2A, 8'h00);
    tick();
    op_valid = 1'b0;
    check("dz_res_valid", 16'(res_valid), 16'h1);
    check("dz_result", result, 16'hFFFF);
    check("dz_err", 16'(err), 16'h1);
    check("dz_starts", starts(), 16'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("dz_release", 16'(res_valid), 16'h0);
    $display("divzero: result=%h err=%b", result, err);

    // Timeout on the multiplier, with stray done pulses from other units
    drive_op(2'b10, 8'h03, 8'h04);
    tick();
    op_valid = 1'b0;
    check("to_issue_starts", starts(), 16'b0010);
    tick();
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      add_done = (i == 10);
      add_res  = 9'h055;
      div_done = (i == 20);
      div_quot = 8'h12; div_rem = 8'h34;
      tick();
      if (res_valid !== 1'b0) early = 1'b1;
    end
    add_done = 1'b0; div_done = 1'b0;
    check("to_no_early_hold", 16'(early), 16'h0);
    tick();
    check("to_res_valid", 16'(res_valid), 16'h1);
    check("to_result", result, 16'h0000);
    check("to_err", 16'(err), 16'h1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("timeout: result=%h err=%b", result, err);

    // Reset while waiting on the divider; the late done must be ignored
    drive_op(2'b11, 8'h64, 8'h05);
    tick();
    op_valid = 1'b0;
    check("rm_issue_starts", starts(), 16'b0001);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    div_done = 1'b1; div_quot = 8'h14; div_rem = 8'h00;
    tick();
    div_done = 1'b0;
    tick();
    check("rm_res_valid", 16'(res_valid), 16'h0);
    check("rm_op_ready", 16'(op_ready), 16'h1);
    check("rm_busy", 16'(busy), 16'h0);
    check("rm_opa", 16'(opa), 16'h0000);
    check("rm_opb", 16'(opb), 16'h0000);
    check("rm_result", result, 16'h0000);
    check("rm_err", 16'(err), 16'h0);
    check("rm_starts", starts(), 16'h0);
    $display("reset-mid-op: res_valid=%b op_ready=%b", res_valid, op_ready);

    // Backpressure: result holds while a new request waits at the input
    drive_op(2'b10, 8'h0F, 8'h11);
    tick();
    op_valid = 1'b0;
    tick();
    mul_done = 1'b1; mul_res = 16'h00FF;
    tick();
    mul_done = 1'b0;
    check("bp_res_valid", 16'(res_valid), 16'h1);
    drive_op(2'b00, 8'hAA, 8'hBB);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_result", result, 16'h00FF);
      check("bp_hold_op_ready", 16'(op_ready), 16'h0);
      check("bp_hold_opa", 16'(opa), 16'h000F);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_release_res_valid", 16'(res_valid), 16'h0);
    check("bp_release_opa", 16'(opa), 16'h000F);
    tick();
    op_valid = 1'b0;
    check("bp_next_opa", 16'(opa), 16'h00AA);
    check("bp_next_opb", 16'(opb), 16'h00BB);
    check("bp_next_starts", starts(), 16'b1000);
    tick();
    add_done = 1'b1; add_res = 9'h165;
    tick();
    add_done = 1'b0;
    check("bp_next_result", result, 16'h0165);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("backpressure: next result=%h", result);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
